// File: rtl/hollywood_hash_lanes.sv
// hollywood_hash_lanes: multi-lane hollywood hash checker with a result FIFO.
// Optional feature macro: HOLLYWOOD_HASH_CSR_EN (runtime-writable target pair).
module hollywood_hash_lanes #(
  parameter int unsigned NUM_LANES = 4,
  parameter logic [15:0] R4        = 16'hFEB1,
  parameter logic [15:0] R6        = 16'h9298,
  parameter int unsigned MAX_WORDS = 16,
  parameter int unsigned MIN_WORDS = 1,
  parameter int unsigned RES_DEPTH = 4,
  localparam int unsigned LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  localparam int unsigned COUNT_W  = $clog2(MAX_WORDS + 1)
) (
  input  logic               clk,
  input  logic               reset,
`ifdef HOLLYWOOD_HASH_CSR_EN
  input  logic               cfg_we,
  input  logic [15:0]        cfg_r4,
  input  logic [15:0]        cfg_r6,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_channel,
  input  logic [LANE_W-1:0]  in_lane,
  input  logic [15:0]        in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANE_W-1:0]  out_lane,
  output logic [COUNT_W-1:0] out_count
);

  localparam int unsigned PTR_W  = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int unsigned FCNT_W = $clog2(RES_DEPTH + 1);

  // Per-lane hash state
  logic [15:0]          r4_q  [NUM_LANES];
  logic [15:0]          r4_d  [NUM_LANES];
  logic [15:0]          r6_q  [NUM_LANES];
  logic [15:0]          r6_d  [NUM_LANES];
  logic [COUNT_W-1:0]   cnt_q [NUM_LANES];
  logic [COUNT_W-1:0]   cnt_d [NUM_LANES];
  logic [NUM_LANES-1:0] ovf_q, ovf_d;

  // Compare-stage snapshot
  logic               chk_vld_q, chk_vld_d;
  logic [LANE_W-1:0]  snap_lane_q, snap_lane_d;
  logic [15:0]        snap_r4_q, snap_r4_d;
  logic [15:0]        snap_r6_q, snap_r6_d;
  logic [COUNT_W-1:0] snap_cnt_q, snap_cnt_d;

  // Result FIFO
  logic [LANE_W-1:0]  fifo_lane_q [RES_DEPTH];
  logic [COUNT_W-1:0] fifo_cnt_q  [RES_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;

  logic               accept, lane_ok, match, push, pop;
  logic [LANE_W-1:0]  lane_idx;
  logic [15:0]        cdab, sum, tgt_r4, tgt_r6;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RES_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

`ifdef HOLLYWOOD_HASH_CSR_EN
  logic [15:0] tgt_r4_q, tgt_r6_q;

  // Target pair registers, reloaded by a config write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tgt_r4_q <= R4;
      tgt_r6_q <= R6;
    end else if (cfg_we) begin
      tgt_r4_q <= cfg_r4;
      tgt_r6_q <= cfg_r6;
    end
  end

  assign tgt_r4 = tgt_r4_q;
  assign tgt_r6 = tgt_r6_q;
`else
  assign tgt_r4 = R4;
  assign tgt_r6 = R6;
`endif

  // Handshake, lane decode and hash datapath
  always_comb begin
    in_ready = ({1'b0, fcnt_q} + (FCNT_W + 1)'(chk_vld_q)) < (FCNT_W + 1)'(RES_DEPTH);
    accept   = in_valid && in_ready;
    lane_ok  = ({1'b0, in_lane} < (LANE_W + 1)'(NUM_LANES));
    lane_idx = lane_ok ? in_lane : '0;
    cdab     = {in_data[7:0], in_data[15:8]};
    sum      = r4_q[lane_idx] + cdab;
  end

  // Lane state next-state and snapshot capture
  always_comb begin
    r4_d        = r4_q;
    r6_d        = r6_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    chk_vld_d   = 1'b0;
    snap_lane_d = snap_lane_q;
    snap_r4_d   = snap_r4_q;
    snap_r6_d   = snap_r6_q;
    snap_cnt_d  = snap_cnt_q;
    if (accept && lane_ok) begin
      if (in_channel) begin
        r4_d[lane_idx]  = '0;
        r6_d[lane_idx]  = '0;
        cnt_d[lane_idx] = '0;
        ovf_d[lane_idx] = 1'b0;
      end else if (!ovf_q[lane_idx]) begin
        if (cnt_q[lane_idx] < COUNT_W'(MAX_WORDS)) begin
          r4_d[lane_idx]  = r6_q[lane_idx] ^ cdab;
          r6_d[lane_idx]  = {sum[7:0], sum[15:8]};
          cnt_d[lane_idx] = cnt_q[lane_idx] + COUNT_W'(1);
          chk_vld_d       = 1'b1;
          snap_lane_d     = lane_idx;
          snap_r4_d       = r6_q[lane_idx] ^ cdab;
          snap_r6_d       = {sum[7:0], sum[15:8]};
          snap_cnt_d      = cnt_q[lane_idx] + COUNT_W'(1);
        end else begin
          ovf_d[lane_idx] = 1'b1;
        end
      end
    end
  end

  // Compare stage and FIFO pointer/occupancy bookkeeping
  always_comb begin
    match     = chk_vld_q && (snap_r4_q == tgt_r4) && (snap_r6_q == tgt_r6) &&
                (snap_cnt_q >= COUNT_W'(MIN_WORDS));
    push      = match;
    out_valid = (fcnt_q != '0);
    pop       = out_valid && out_ready;
    out_lane  = fifo_lane_q[rd_ptr_q];
    out_count = fifo_cnt_q[rd_ptr_q];
    wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fcnt_d    = fcnt_q;
    if (push && !pop)      fcnt_d = fcnt_q + FCNT_W'(1);
    else if (pop && !push) fcnt_d = fcnt_q - FCNT_W'(1);
  end

  // Lane state, snapshot and FIFO registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        r4_q[i]  <= '0;
        r6_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      ovf_q       <= '0;
      chk_vld_q   <= 1'b0;
      snap_lane_q <= '0;
      snap_r4_q   <= '0;
      snap_r6_q   <= '0;
      snap_cnt_q  <= '0;
      for (int j = 0; j < RES_DEPTH; j++) begin
        fifo_lane_q[j] <= '0;
        fifo_cnt_q[j]  <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      r4_q        <= r4_d;
      r6_q        <= r6_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      chk_vld_q   <= chk_vld_d;
      snap_lane_q <= snap_lane_d;
      snap_r4_q   <= snap_r4_d;
      snap_r6_q   <= snap_r6_d;
      snap_cnt_q  <= snap_cnt_d;
      if (push) begin
        fifo_lane_q[wr_ptr_q] <= snap_lane_q;
        fifo_cnt_q[wr_ptr_q]  <= snap_cnt_q;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
    end
  end

endmodule
